// File: rtl/fwd_hazard_unit_if.sv
// DE-side bundle of the forwarding/hazard unit.
// Master is the pipeline control; slave is fwd_hazard_unit.
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int LAT_W   = 6,
  parameter int SEL_W   = 2
);
  logic                     ADV;
  logic                     FLUSH;
  logic [NUM_SRC*5-1:0]     RS_DE;
  logic [NUM_SRC-1:0]       RS_USED_DE;
  logic [4:0]               RD_DE;
  logic                     RegWrite_DE;
  logic                     IsLoad_DE;
  logic                     IsLong_DE;
  logic [LAT_W-1:0]         LAT_DE;
  logic [NUM_SRC*SEL_W-1:0] FWD_SEL;
  logic                     STALL;
  logic                     LONG_BUSY;
  logic                     LONG_DONE;
  logic [4:0]               LONG_RD;

  modport master (
    output ADV, FLUSH, RS_DE, RS_USED_DE, RD_DE,
    output RegWrite_DE, IsLoad_DE, IsLong_DE, LAT_DE,
    input  FWD_SEL, STALL, LONG_BUSY, LONG_DONE, LONG_RD
  );

  modport slave (
    input  ADV, FLUSH, RS_DE, RS_USED_DE, RD_DE,
    input  RegWrite_DE, IsLoad_DE, IsLong_DE, LAT_DE,
    output FWD_SEL, STALL, LONG_BUSY, LONG_DONE, LONG_RD
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select, load-use and long-op hazard unit
// beside the DE register; tracks DEPTH in-flight writes.
module fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int LAT_W   = 6,
  parameter int SEL_W   = $clog2(DEPTH+1)
) (
  input logic            clk,
  input logic            rst_n,
  fwd_hazard_unit_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
  } rec_t;

  rec_t                     rec [1:DEPTH];
  rec_t                     de_rec;
  logic [DEPTH:1]           writer;
  logic [4:0]               src [NUM_SRC];
  logic [NUM_SRC-1:0]       used;
  logic [NUM_SRC*SEL_W-1:0] sel;

  logic             long_busy;
  logic [LAT_W-1:0] long_cnt;
  logic [4:0]       long_rd;
  logic [LAT_W-1:0] lat_eff;

  logic long_done;
  logic load_use;
  logic long_hit;
  logic long_stall;
  logic stall;
  logic issue;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src[g]  = bus.RS_DE[5*g +: 5];
    assign used[g] = bus.RS_USED_DE[g] && (src[g] != 5'd0);
  end

  for (genvar k = 1; k <= DEPTH; k++) begin : g_wr
    assign writer[k] = rec[k].valid && rec[k].regwrite
                       && (rec[k].rd != 5'd0);
  end

  // ascending scan so the youngest matching record wins
  always_comb begin
    sel      = '0;
    load_use = 1'b0;
    long_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (used[i] && writer[k] && rec[k].rd == src[i])
          sel[i*SEL_W +: SEL_W] = SEL_W'(k);
      end
      if (used[i] && writer[DEPTH] && rec[DEPTH].load
          && rec[DEPTH].rd == src[i])
        load_use = 1'b1;
      if (used[i] && src[i] == long_rd)
        long_hit = 1'b1;
    end
  end

  assign long_done  = long_busy && (long_cnt == '0);
  assign long_stall = long_busy && (long_hit || bus.IsLong_DE
                      || (bus.RegWrite_DE && bus.RD_DE == long_rd));
  assign stall      = (load_use || long_stall) && !bus.FLUSH;
  assign issue      = bus.ADV && !bus.FLUSH && !stall;
  assign lat_eff    = (bus.LAT_DE == '0) ? LAT_W'(1) : bus.LAT_DE;

  // long ops never forward; their write belongs to the long slot
  assign de_rec = {1'b1, bus.RD_DE,
                   bus.RegWrite_DE && !bus.IsLong_DE,
                   bus.IsLoad_DE};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) rec[k] <= '0;
    end else if (bus.ADV) begin
      for (int k = 1; k < DEPTH; k++) rec[k] <= rec[k+1];
      rec[DEPTH] <= issue ? de_rec : '0;
    end
  end

  // counter runs independently of ADV
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_busy <= 1'b0;
      long_cnt  <= '0;
      long_rd   <= 5'd0;
    end else begin
      if (long_busy) begin
        if (long_cnt == '0) long_busy <= 1'b0;
        else                long_cnt  <= long_cnt - 1'b1;
      end
      if (issue && bus.IsLong_DE) begin
        long_busy <= 1'b1;
        long_rd   <= bus.RD_DE;
        long_cnt  <= lat_eff;
      end
    end
  end

  assign bus.FWD_SEL   = sel;
  assign bus.STALL     = stall;
  assign bus.LONG_BUSY = long_busy;
  assign bus.LONG_DONE = long_done;
  assign bus.LONG_RD   = long_rd;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: cycle table with scoreboard,
// reset-abort sequence and a DEPTH=3/NUM_SRC=3 build.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NUM_SRC(2), .LAT_W(6), .SEL_W(2)) bus ();
  fwd_hazard_unit_if #(.NUM_SRC(3), .LAT_W(6), .SEL_W(2)) b3 ();

  fwd_hazard_unit #(.NUM_SRC(2), .DEPTH(2), .LAT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  fwd_hazard_unit #(.NUM_SRC(3), .DEPTH(3), .LAT_W(6)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  typedef struct packed {
    logic       adv;
    logic       flush;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       lng;
    logic [5:0] lat;
    logic [1:0] s0;
    logic [1:0] s1;
    logic       stall;
    logic       busy;
    logic       done;
    logic [4:0] lrd;
    logic       csel;
  } vec_t;

  vec_t tbl [$];
  vec_t sb  [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(
    input int adv, flush, rs0, rs1, used, rd, rw, ld, lng, lat,
    input int s0, s1, stall, busy, done, lrd, csel);
    vec_t v;
    v.adv = 1'(adv);     v.flush = 1'(flush);
    v.rs0 = 5'(rs0);     v.rs1 = 5'(rs1);
    v.used = 2'(used);   v.rd = 5'(rd);
    v.rw = 1'(rw);       v.ld = 1'(ld);
    v.lng = 1'(lng);     v.lat = 6'(lat);
    v.s0 = 2'(s0);       v.s1 = 2'(s1);
    v.stall = 1'(stall); v.busy = 1'(busy);
    v.done = 1'(done);   v.lrd = 5'(lrd);
    v.csel = 1'(csel);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic apply(input vec_t v);
    bus.ADV         = v.adv;
    bus.FLUSH       = v.flush;
    bus.RS_DE       = {v.rs1, v.rs0};
    bus.RS_USED_DE  = v.used;
    bus.RD_DE       = v.rd;
    bus.RegWrite_DE = v.rw;
    bus.IsLoad_DE   = v.ld;
    bus.IsLong_DE   = v.lng;
    bus.LAT_DE      = v.lat;
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  vec_t idle;
  vec_t e;

  initial begin
    idle = mk(1,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,1);
    apply(idle);
    b3.ADV = 1'b0;   b3.FLUSH = 1'b0;
    b3.RS_DE = '0;   b3.RS_USED_DE = '0;
    b3.RD_DE = '0;   b3.RegWrite_DE = 1'b0;
    b3.IsLoad_DE = 1'b0; b3.IsLong_DE = 1'b0;
    b3.LAT_DE = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sel",  int'(bus.FWD_SEL),   0);
    chk("rst_stall",int'(bus.STALL),     0);
    chk("rst_busy", int'(bus.LONG_BUSY), 0);
    chk("rst_done", int'(bus.LONG_DONE), 0);
    chk("rst_lrd",  int'(bus.LONG_RD),   0);
    chk("rst_sel3", int'(b3.FWD_SEL),    0);
    step_edge();

    // adv fl rs0 rs1 used rd rw ld lng lat | s0 s1 st by dn lrd csel
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,0,0,  0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,0, 5,1,0,0,0,  0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 5,0,1, 5,1,0,0,0,  2,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 5,0,1, 0,0,0,0,0,  2,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 5,5,3, 0,0,0,0,0,  1,1,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,0, 0,1,0,0,0,  0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,3, 6,1,0,0,0,  0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 3,6,1, 0,0,0,0,0,  0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,0, 7,1,1,0,0,  0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 7,0,1, 0,0,0,0,0,  0,0,1,0,0,0,0));
    tbl.push_back(mk(1,0, 7,0,1, 0,0,0,0,0,  1,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,0, 8,1,1,0,0,  0,0,0,0,0,0,1));
    tbl.push_back(mk(1,1, 8,0,1, 20,1,1,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0, 8,20,3, 0,0,0,0,0, 1,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,0, 9,1,0,1,4,  0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 9,0,1, 0,0,0,0,0,  0,0,1,1,0,9,1));
    tbl.push_back(mk(1,0, 9,0,1, 0,0,0,0,0,  0,0,1,1,0,9,1));
    tbl.push_back(mk(1,0, 9,0,1, 0,0,0,0,0,  0,0,1,1,0,9,1));
    tbl.push_back(mk(1,0, 9,0,1, 0,0,0,0,0,  0,0,1,1,0,9,1));
    tbl.push_back(mk(1,0, 9,0,1, 0,0,0,0,0,  0,0,1,1,1,9,1));
    tbl.push_back(mk(1,0, 9,0,1, 11,1,0,0,0, 0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,0, 10,1,0,1,0, 0,0,0,0,0,0,1));
    tbl.push_back(mk(0,0, 0,11,2, 10,1,0,0,0, 0,1,1,1,0,10,1));
    tbl.push_back(mk(0,0, 0,11,2, 10,1,0,0,0, 0,1,1,1,1,10,1));
    tbl.push_back(mk(0,0, 0,11,2, 10,1,0,0,0, 0,1,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,11,2, 10,1,0,0,0, 0,1,0,0,0,0,1));
    tbl.push_back(mk(1,0, 10,0,1, 12,1,0,1,2, 2,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,0, 13,1,0,1,1, 0,0,1,1,0,12,1));
    tbl.push_back(mk(1,0, 0,0,0, 13,1,0,1,1, 0,0,1,1,0,12,1));
    tbl.push_back(mk(1,0, 0,0,0, 13,1,0,1,1, 0,0,1,1,1,12,1));
    tbl.push_back(mk(1,0, 0,0,0, 13,1,0,1,1, 0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,0,0,  0,0,0,1,0,13,1));
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,0,0,  0,0,0,1,1,13,1));
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,0,0,  0,0,0,0,0,0,1));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      if (e.csel) begin
        chk($sformatf("sel0[%0d]", i), int'(bus.FWD_SEL[1:0]), int'(e.s0));
        chk($sformatf("sel1[%0d]", i), int'(bus.FWD_SEL[3:2]), int'(e.s1));
      end
      chk($sformatf("stall[%0d]", i), int'(bus.STALL), int'(e.stall));
      chk($sformatf("busy[%0d]", i), int'(bus.LONG_BUSY), int'(e.busy));
      chk($sformatf("done[%0d]", i), int'(bus.LONG_DONE), int'(e.done));
      if (e.busy)
        chk($sformatf("lrd[%0d]", i), int'(bus.LONG_RD), int'(e.lrd));
      step_edge();
    end

    // reset while a long op is pending: no done pulse afterwards
    apply(mk(1,0, 0,0,0, 14,1,0,1,3, 0,0,0,0,0,0,1));
    step_edge();
    apply(idle);
    @(negedge clk);
    chk("abort_busy", int'(bus.LONG_BUSY), 1);
    chk("abort_lrd",  int'(bus.LONG_RD),  14);
    rst_n = 1'b0;
    step_edge();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("abort_busy[%0d]", c), int'(bus.LONG_BUSY), 0);
      chk($sformatf("abort_done[%0d]", c), int'(bus.LONG_DONE), 0);
      chk($sformatf("abort_lrd[%0d]", c),  int'(bus.LONG_RD),   0);
      step_edge();
    end

    // DEPTH=3 build: x3, x2, x1 end up in records 1, 2, 3
    b3.ADV = 1'b1;
    b3.RegWrite_DE = 1'b1;
    b3.RD_DE = 5'd3; step_edge();
    b3.RD_DE = 5'd2; step_edge();
    b3.RD_DE = 5'd1; step_edge();
    b3.RegWrite_DE = 1'b0;
    b3.RD_DE = 5'd0;
    b3.RS_DE = {5'd3, 5'd2, 5'd1};
    b3.RS_USED_DE = 3'b111;
    @(negedge clk);
    chk("d3_sel0", int'(b3.FWD_SEL[1:0]), 3);
    chk("d3_sel1", int'(b3.FWD_SEL[3:2]), 2);
    chk("d3_sel2", int'(b3.FWD_SEL[5:4]), 1);
    chk("d3_stall", int'(b3.STALL), 0);
    step_edge();
    @(negedge clk);
    chk("d3_age_sel0", int'(b3.FWD_SEL[1:0]), 2);
    chk("d3_age_sel1", int'(b3.FWD_SEL[3:2]), 1);
    chk("d3_age_sel2", int'(b3.FWD_SEL[5:4]), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
